// File: rtl/ysyx_24100005_imem_resp.sv
// -----------------------------------------------------------------------------
// ysyx_24100005_imem_resp
//
// Instruction memory with a valid/ready request and response handshake and a
// fixed, parameterised response latency. One fetch is outstanding at a time.
// A backdoor port writes words directly, for loaders and benches.
//
// Parameters
//   BASE    byte address of word 0
//   AW      log2 of the word depth
//   LATENCY cycles from request acceptance to rsp_valid (1..7)
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready/req_addr  fetch request (byte address)
//   rsp_valid/rsp_ready           response handshake
//   rsp_inst, rsp_err             fetched word and address-fault flag
//   load_en/load_idx/load_data    backdoor word write, accepted in any state
//
// Optional feature
//   YSYX_24100005_IMEM_ALIGN_CHECK_EN  when defined, an address with non-zero
//   bits [1:0] faults. When undefined, those bits are ignored.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module ysyx_24100005_imem_resp #(
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int          AW      = 12,
   parameter int          LATENCY = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [31:0]   req_addr,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_inst,
   output logic          rsp_err,
   input  logic          load_en,
   input  logic [AW-1:0] load_idx,
   input  logic [31:0]   load_data
);

   localparam logic [31:0] EBREAK   = 32'h0010_0073;
   localparam logic [2:0]  CNT_LOAD = 3'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [2:0]    cnt_r;
   logic [2:0]    cnt_nxt_s;
   logic [31:0]   addr_r;
   logic [31:0]   fetch_addr_s;
   logic [31:0]   off_s;
   logic [AW-1:0] idx_s;
   logic          fault_s;
   logic          accept_s;
   logic          enter_resp_s;
   logic          req_ready_nxt_s;
   logic          rsp_valid_nxt_s;
   logic          req_ready_r;
   logic          rsp_valid_r;
   logic          rsp_err_r;
   logic [31:0]   rsp_inst_r;
   logic [31:0]   mem_r [0:(2**AW)-1];

   // Address fault: below BASE, beyond the last word (no wrap), or misaligned
   // when the alignment check is built in.
   function automatic logic addr_fault(input logic [31:0] addr, input logic [31:0] off);
      logic bad;
      bad = (addr < BASE) || ((off >> (AW + 2)) != 32'd0);
`ifdef YSYX_24100005_IMEM_ALIGN_CHECK_EN
      bad = bad || (addr[1:0] != 2'b00);
`endif
      return bad;
   endfunction

   // Fetch address: the live request when a LATENCY=1 fetch resolves straight
   // out of IDLE, the latched address otherwise.
   always_comb begin
      accept_s     = (state_r == IDLE) && req_ready_r && req_valid;
      fetch_addr_s = (state_r == IDLE) ? req_addr : addr_r;
      off_s        = fetch_addr_s - BASE;
      idx_s        = off_s[AW+1:2];
      fault_s      = addr_fault(fetch_addr_s, off_s);
   end

   // Next-state logic. The counter holds the cycles still to wait; WAIT is left
   // on the edge that would take it to zero, so rsp_valid appears exactly
   // LATENCY cycles after the acceptance edge for every legal LATENCY.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               cnt_nxt_s   = CNT_LOAD;
               state_nxt_s = (LATENCY == 1) ? RESP : WAIT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r <= 3'd1) begin
               cnt_nxt_s   = 3'd0;
               state_nxt_s = RESP;
            end else begin
               cnt_nxt_s   = cnt_r - 3'd1;
               state_nxt_s = WAIT;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 3'd0;
         end
      endcase
   end

   // Output decode, registered below so every output comes straight from a flop.
   always_comb begin
      req_ready_nxt_s = (state_nxt_s == IDLE);
      rsp_valid_nxt_s = (state_nxt_s == RESP);
      enter_resp_s    = (state_nxt_s == RESP) && (state_r != RESP);
   end

   // State, counter, latched address and registered outputs.
   // The response word is captured on the edge entering RESP, so a backdoor
   // write on that same edge is not seen but any earlier one is.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= 3'd0;
         addr_r      <= 32'd0;
         req_ready_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_inst_r  <= 32'd0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         req_ready_r <= req_ready_nxt_s;
         rsp_valid_r <= rsp_valid_nxt_s;
         if (accept_s) begin
            addr_r <= req_addr;
         end
         if (enter_resp_s) begin
            rsp_err_r  <= fault_s;
            rsp_inst_r <= fault_s ? EBREAK : mem_r[idx_s];
         end
      end
   end

   // Backdoor write port; memory contents survive reset.
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem_r[load_idx] <= load_data;
      end
   end

   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_inst  = rsp_inst_r;
   assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_ysyx_24100005_imem_resp.sv
// -----------------------------------------------------------------------------
// tb_ysyx_24100005_imem_resp
//
// Self-checking bench. Three instances with LATENCY 1, 3 and 4 share clock,
// reset and the backdoor load port. Expected responses come from a reference
// memory model and travel through a scoreboard queue.
// Honours YSYX_24100005_IMEM_ALIGN_CHECK_EN in its model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ysyx_24100005_imem_resp;

   localparam int          N      = 3;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef struct packed {
      logic [31:0] inst;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_valid [N];
   logic        req_ready [N];
   logic [31:0] req_addr  [N];
   logic        rsp_valid [N];
   logic        rsp_ready [N];
   logic [31:0] rsp_inst  [N];
   logic        rsp_err   [N];
   logic        load_en;
   logic [11:0] load_idx;
   logic [31:0] load_data;

   logic [31:0] model_mem [4096];
   exp_t        sb_q [$];
   int          checks;
   int          errors;

   for (genvar g = 0; g < N; g++) begin : g_dut
      ysyx_24100005_imem_resp #(
         .BASE    (32'h8000_0000),
         .AW      (12),
         .LATENCY ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_addr  (req_addr[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_inst  (rsp_inst[g]),
         .rsp_err   (rsp_err[g]),
         .load_en   (load_en),
         .load_idx  (load_idx),
         .load_data (load_data)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model_fetch(input logic [31:0] addr);
      logic [31:0] off;
      exp_t        e;
      off = addr - 32'h8000_0000;
      e.err  = (addr < 32'h8000_0000) || (off[31:14] != 18'd0);
`ifdef YSYX_24100005_IMEM_ALIGN_CHECK_EN
      e.err  = e.err || (addr[1:0] != 2'b00);
`endif
      e.inst = e.err ? EBREAK : model_mem[off[13:2]];
      return e;
   endfunction

   task automatic load(input int idx, input logic [31:0] data);
      load_en   = 1'b1;
      load_idx  = 12'(idx);
      load_data = data;
      @(posedge clk); #1;
      load_en = 1'b0;
      model_mem[idx] = data;
   endtask

   // Drives one fetch on instance d and reports what was observed.
   task automatic fetch(input int d, input logic [31:0] addr, input int stall,
                        output logic [31:0] inst, output logic err, output int lat,
                        output logic stable, output logic rdy_low,
                        output logic post_valid, output logic timeout);
      int n;
      timeout = 1'b0;
      n = 0;
      while (!req_ready[d] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready[d]) timeout = 1'b1;
      req_valid[d] = 1'b1;
      req_addr[d]  = addr;
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      req_addr[d]  = $urandom;
      lat = 1;
      rdy_low = !req_ready[d];
      while (!rsp_valid[d] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (req_ready[d]) rdy_low = 1'b0;
      end
      if (!rsp_valid[d]) timeout = 1'b1;
      inst   = rsp_inst[d];
      err    = rsp_err[d];
      stable = 1'b1;
      if (req_ready[d]) rdy_low = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         if (rsp_inst[d] !== inst || rsp_err[d] !== err || rsp_valid[d] !== 1'b1) stable = 1'b0;
         if (req_ready[d]) rdy_low = 1'b0;
      end
      rsp_ready[d] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[d] = 1'b0;
      post_valid = rsp_valid[d];
   endtask

   task automatic test_reset();
      for (int d = 0; d < N; d++) begin
         checks++;
         if (rsp_valid[d] !== 1'b0 || rsp_err[d] !== 1'b0 || rsp_inst[d] !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs[%0d]: got valid=%b err=%b inst=%h, expected 0/0/00000000",
                     d, rsp_valid[d], rsp_err[d], rsp_inst[d]);
         end
      end
      rst = 1'b0;
      checks++;
      if (req_ready[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_early: got %b, expected 0", req_ready[0]);
      end
      @(posedge clk); #1;
      checks++;
      if (req_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_after: got %b, expected 1", req_ready[0]);
      end
   endtask

   task automatic test_basic();
      logic [31:0] inst;
      logic        err, stable, rdy_low, post_valid, timeout;
      int          lat;
      exp_t        e;
      load(0, 32'h0010_0093);
      sb_q.push_back(model_fetch(32'h8000_0000));
      fetch(0, 32'h8000_0000, 0, inst, err, lat, stable, rdy_low, post_valid, timeout);
      e = sb_q.pop_front();
      checks++;
      if (timeout || lat != 1) begin
         errors++;
         $display("FAIL basic_latency: got %0d (timeout=%b), expected 1", lat, timeout);
      end
      checks++;
      if (inst !== e.inst || err !== e.err) begin
         errors++;
         $display("FAIL basic_data: got %h/%b, expected %h/%b", inst, err, e.inst, e.err);
      end
      checks++;
      if (post_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_release: got rsp_valid=%b, expected 0", post_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] inst;
      logic        err, stable, rdy_low, post_valid, timeout;
      int          lat;
      exp_t        e;
      load(7, $urandom);
      sb_q.push_back(model_fetch(32'h8000_001C));
      fetch(2, 32'h8000_001C, 3, inst, err, lat, stable, rdy_low, post_valid, timeout);
      e = sb_q.pop_front();
      checks++;
      if (timeout || lat != 4) begin
         errors++;
         $display("FAIL bp_latency: got %0d (timeout=%b), expected 4", lat, timeout);
      end
      checks++;
      if (inst !== e.inst || err !== e.err) begin
         errors++;
         $display("FAIL bp_data: got %h/%b, expected %h/%b", inst, err, e.inst, e.err);
      end
      checks++;
      if (stable !== 1'b1 || rdy_low !== 1'b1) begin
         errors++;
         $display("FAIL bp_hold: got stable=%b ready_low=%b, expected 1/1", stable, rdy_low);
      end
      checks++;
      if (post_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: got rsp_valid=%b, expected 0", post_valid);
      end
   endtask

   task automatic test_range_and_align();
      logic [31:0] addrs [7];
      int          devs  [7];
      logic [31:0] inst;
      logic        err, stable, rdy_low, post_valid, timeout;
      int          lat;
      exp_t        e;
      addrs = '{32'h8000_3FFC, 32'h8000_4000, 32'h7FFF_FFFC, 32'hFFFF_FFFC,
                32'h8000_0000, 32'h8000_0002, 32'h8000_3FFF};
      devs  = '{0, 0, 0, 2, 1, 1, 2};
      load(4095, $urandom);
      for (int i = 0; i < 7; i++) begin
         sb_q.push_back(model_fetch(addrs[i]));
         fetch(devs[i], addrs[i], i % 2, inst, err, lat, stable, rdy_low, post_valid, timeout);
         e = sb_q.pop_front();
         checks++;
         if (timeout || inst !== e.inst || err !== e.err) begin
            errors++;
            $display("FAIL range_align[%h]: got %h/%b (timeout=%b), expected %h/%b",
                     addrs[i], inst, err, timeout, e.inst, e.err);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] inst;
      logic        err, stable, rdy_low, post_valid, timeout, spurious;
      int          lat;
      exp_t        e;
      req_valid[0] = 1'b1;  req_addr[0] = 32'h8000_0000;
      req_valid[1] = 1'b1;  req_addr[1] = 32'h8000_0000;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b0;
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
         errors++;
         $display("FAIL rmid_pre: got valid0=%b valid1=%b, expected 1/0", rsp_valid[0], rsp_valid[1]);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (rsp_valid[0] !== 1'b0 || rsp_inst[0] !== 32'd0 || rsp_err[0] !== 1'b0) begin
         errors++;
         $display("FAIL rmid_async: got %b/%h/%b, expected 0/00000000/0",
                  rsp_valid[0], rsp_inst[0], rsp_err[0]);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      spurious = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         for (int d = 0; d < N; d++) if (rsp_valid[d] !== 1'b0) spurious = 1'b1;
      end
      checks++;
      if (spurious) begin
         errors++;
         $display("FAIL rmid_no_response: got a response after abort, expected none");
      end
      sb_q.push_back(model_fetch(32'h8000_0000));
      fetch(1, 32'h8000_0000, 0, inst, err, lat, stable, rdy_low, post_valid, timeout);
      e = sb_q.pop_front();
      checks++;
      if (timeout || lat != 3 || inst !== e.inst || err !== e.err) begin
         errors++;
         $display("FAIL rmid_next: got %h/%b lat=%0d, expected %h/%b lat=3", inst, err, lat, e.inst, e.err);
      end
   endtask

   task automatic test_load_hazard();
      int          n;
      exp_t        e;
      logic [31:0] inst;
      logic        err, stable, rdy_low, post_valid, timeout;
      int          lat;
      // Load during WAIT must be visible.
      load(5, 32'h0BAD_0005);
      req_valid[1] = 1'b1;
      req_addr[1]  = 32'h8000_0014;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      load_en = 1'b1;  load_idx = 12'd5;  load_data = 32'hDEAD_BEEF;
      sb_q.push_back('{inst: 32'hDEAD_BEEF, err: 1'b0});
      @(posedge clk); #1;
      load_en = 1'b0;
      model_mem[5] = 32'hDEAD_BEEF;
      n = 0;
      while (!rsp_valid[1] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      e = sb_q.pop_front();
      checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_inst[1] !== e.inst || rsp_err[1] !== e.err) begin
         errors++;
         $display("FAIL hazard_wait: got %b/%h/%b, expected 1/%h/%b",
                  rsp_valid[1], rsp_inst[1], rsp_err[1], e.inst, e.err);
      end
      rsp_ready[1] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[1] = 1'b0;
      // Load on the same edge the response is captured returns old data.
      load(6, 32'h1111_1111);
      sb_q.push_back(model_fetch(32'h8000_0018));
      req_valid[1] = 1'b1;
      req_addr[1]  = 32'h8000_0018;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      load_en = 1'b1;  load_idx = 12'd6;  load_data = 32'h2222_2222;
      @(posedge clk); #1;
      load_en = 1'b0;
      model_mem[6] = 32'h2222_2222;
      e = sb_q.pop_front();
      checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_inst[1] !== e.inst || rsp_err[1] !== e.err) begin
         errors++;
         $display("FAIL hazard_same_edge: got %b/%h/%b, expected 1/%h/%b",
                  rsp_valid[1], rsp_inst[1], rsp_err[1], e.inst, e.err);
      end
      rsp_ready[1] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[1] = 1'b0;
      sb_q.push_back(model_fetch(32'h8000_0018));
      fetch(1, 32'h8000_0018, 0, inst, err, lat, stable, rdy_low, post_valid, timeout);
      e = sb_q.pop_front();
      checks++;
      if (timeout || inst !== e.inst || err !== e.err) begin
         errors++;
         $display("FAIL hazard_after: got %h/%b, expected %h/%b", inst, err, e.inst, e.err);
      end
   endtask

   task automatic test_back_to_back();
      int   cnt;
      logic overlap;
      cnt = 0;
      overlap = 1'b0;
      req_valid[0] = 1'b1;
      req_addr[0]  = 32'h8000_0000;
      rsp_ready[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (rsp_valid[0] === 1'b1) cnt++;
         if (rsp_valid[0] === 1'b1 && req_ready[0] === 1'b1) overlap = 1'b1;
      end
      req_valid[0] = 1'b0;
      rsp_ready[0] = 1'b0;
      checks++;
      if (cnt != 4 || overlap) begin
         errors++;
         $display("FAIL back_to_back: got %0d responses overlap=%b, expected 4 and 0", cnt, overlap);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      load_en = 1'b0;
      load_idx = 12'd0;
      load_data = 32'd0;
      for (int d = 0; d < N; d++) begin
         req_valid[d] = 1'b0;
         req_addr[d]  = 32'd0;
         rsp_ready[d] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_backpressure();
      test_range_and_align();
      test_reset_mid();
      test_load_hazard();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_24100005_imem_resp.md
YSYX_24100005_IMEM_RESP -- requirements
Module: ysyx_24100005_imem_resp

Interface
REQ-001 SHALL have parameter BASE, default 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter AW, default 12, log2 of the word depth (4096 x 32-bit words).
REQ-003 SHALL have parameter LATENCY, default 1, with legal range 1..7; LATENCY is the number of cycles from request acceptance to rsp_valid.
REQ-004 clk  in  1  clock; single clock domain; all state updates on posedge clk.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 req_valid  in  1  fetch request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_addr  in  32  fetch byte address (core PC).
REQ-009 rsp_valid  out  1  response present.
REQ-010 rsp_ready  in  1  core accepts the response.
REQ-011 rsp_inst  out  32  fetched instruction.
REQ-012 rsp_err  out  1  address fault for this response.
REQ-013 load_en  in  1  backdoor write strobe (bench/loader use).
REQ-014 load_idx  in  AW  backdoor word index.
REQ-015 load_data  in  32  backdoor word data.

Function
REQ-016 SHALL implement an FSM with three states: IDLE, WAIT and RESP.
REQ-017 IDLE: req_ready=1 and rsp_valid=0; req_valid=1 latches req_addr, loads the counter with LATENCY-1 and moves to WAIT, or directly to RESP if LATENCY=1.
REQ-018 WAIT: req_ready=0; the counter decrements each cycle; when the counter is 0 the block moves to RESP on the next edge.
REQ-019 RESP: rsp_valid=1; rsp_inst and rsp_err are held stable until the rsp_ready handshake; rsp_valid & rsp_ready returns the block to IDLE.
REQ-020 Only one request SHALL be outstanding at a time; req_ready SHALL be 1 only in IDLE, so there are no back-to-back responses and the minimum period is LATENCY+1 cycles.
REQ-021 Word index SHALL be (latched_addr - BASE) >> 2, with the subtraction performed modulo 2^32.
REQ-022 In-range condition: latched_addr >= BASE and index < 2^AW; an out-of-range address SHALL give rsp_err=1 and rsp_inst=32'h0010_0073 (ebreak).
REQ-023 For an in-range address, rsp_inst SHALL be the memory word value at the moment RESP is entered, and rsp_err=0.
REQ-024 The address BASE + 4*(2^AW) - 4 SHALL be in range; BASE + 4*(2^AW) SHALL fault; there is no wrap-around into word 0.
REQ-025 load_en SHALL write load_data to word load_idx at the clock edge, in any state.
REQ-026 A simultaneous load and fetch of the same word that completes in the same cycle SHALL return the old data; a load during WAIT to the latched word SHALL be visible in the response.
REQ-027 In IDLE, req_addr SHALL be sampled only on the edge where req_valid is 1; changes to req_addr after acceptance SHALL be ignored.

Reset
REQ-028 rst=1 SHALL force, asynchronously, state to IDLE, counter to 0, rsp_valid=0, rsp_err=0 and rsp_inst=0; req_ready=1 follows one cycle after rst deasserts.
REQ-029 rst asserted in WAIT or RESP SHALL abort the transaction without emitting a response.
REQ-030 Memory contents SHALL NOT be cleared by rst.

Configuration
REQ-031 Macro YSYX_24100005_IMEM_ALIGN_CHECK_EN SHALL control the alignment check.
REQ-032 With the macro defined, latched_addr[1:0] != 0 SHALL give rsp_err=1 and rsp_inst=32'h0010_0073, with the same latency as a normal fetch.
REQ-033 Without the macro, addr[1:0] SHALL be ignored: the word at the truncated index is returned and no alignment fault is raised.

Verification
REQ-034 Basic fetch: with LATENCY=1, load word 0 = 32'h0010_0093 and request 32'h8000_0000 -> rsp_valid one cycle after acceptance, rsp_inst=32'h0010_0093, rsp_err=0.
REQ-035 Multi-cycle latency and backpressure: with LATENCY=4, issue a request with rsp_ready=0 for 3 cycles -> rsp_valid rises 4 cycles after acceptance, rsp_inst is held stable while stalled, and req_ready=0 until the handshake.
REQ-036 Range edges: with AW=12, request 32'h8000_3FFC -> word 4095, rsp_err=0; request 32'h8000_4000 -> rsp_err=1, rsp_inst=32'h0010_0073; request 32'h7FFF_FFFC -> rsp_err=1.
REQ-037 Misalignment: request 32'h8000_0002 with the macro defined -> rsp_err=1, ebreak returned; without the macro -> rsp_err=0 and word 0 returned.
REQ-038 Reset mid-transaction: with LATENCY=3, assert rst in WAIT -> rsp_valid=0 immediately, no response follows, and the next request completes normally.
REQ-039 Load hazard: with LATENCY=3, load word 5 = 32'hDEAD_BEEF during WAIT of a fetch of 32'h8000_0014 -> rsp_inst=32'hDEAD_BEEF.
